// File: rtl/dmem_access_arbiter_if.sv
// Requester-side bundle for dmem_access_arbiter: one instance per port.
// master = requester (CPU LSU or debug/DMA loader), slave = arbiter.
interface dmem_access_arbiter_if #(
  parameter int ADDR_W = 32
);
  logic              req;
  logic              we;
  logic [2:0]        op;
  logic [ADDR_W-1:0] addr;
  logic [31:0]       wdata;
  logic              gnt;
  logic              rvalid;
  logic [31:0]       rdata;
  logic              err;

  modport master (
    output req, we, op, addr, wdata,
    input  gnt, rvalid, rdata, err
  );

  modport slave (
    input  req, we, op, addr, wdata,
    output gnt, rvalid, rdata, err
  );
endinterface

// File: rtl/dmem_access_arbiter.sv
// Two-port data-memory arbiter: IDLE/ACCESS/RESP sequencer with legality check.
// Define ARB_ROUND_ROBIN_EN for round-robin arbitration; default is port-0 priority.
module dmem_access_arbiter #(
  parameter int MEM_BYTES = 4096,
  parameter int ADDR_W    = 32
) (
  input  logic                clk,
  input  logic                rst,
  dmem_access_arbiter_if.slave r0,
  dmem_access_arbiter_if.slave r1,
  output logic                mem_en,
  output logic                mem_wren,
  output logic [2:0]          mem_op,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [31:0]         mem_wdata,
  input  logic [31:0]         mem_rdata
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} arbState;
  typedef logic [ADDR_W:0] wideAddr;

  arbState           state, nextState;
  logic              anyReq, accept, winner, legal;
  logic              curPort, curWe;
  logic [2:0]        curOp;
  logic [ADDR_W-1:0] curAddr;
  logic [31:0]       curWdata, accessData;
  wideAddr           accSize, lastByte;
  logic [1:0]        gntQ, rvalidQ, errQ;
  logic [1:0][31:0]  rdataQ;

  assign anyReq = r0.req | r1.req;
  assign accept = (state == IDLE) && anyReq;

`ifdef ARB_ROUND_ROBIN_EN
  logic lastGnt;

  always_comb begin
    winner = r1.req;
    if (r0.req && r1.req) winner = ~lastGnt;
  end

  always_ff @(posedge clk) begin
    if (rst)         lastGnt <= 1'b0;
    else if (accept) lastGnt <= winner;
  end
`else
  assign winner = ~r0.req;
`endif

  // Last byte touched is formed one bit wider so an address wrap reads as out of range.
  always_comb begin
    case (curOp[1:0])
      2'b00:   accSize = wideAddr'(4);
      2'b10:   accSize = wideAddr'(2);
      default: accSize = wideAddr'(1);
    endcase
    lastByte = {1'b0, curAddr} + accSize - wideAddr'(1);
    legal = 1'b1;
    if (curOp inside {3'b011, 3'b100, 3'b111})     legal = 1'b0;
    if (curWe && (curOp inside {3'b101, 3'b110}))  legal = 1'b0;
    if (lastByte >= wideAddr'(MEM_BYTES))          legal = 1'b0;
  end

  assign accessData = (legal && !curWe) ? mem_rdata : 32'h0;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= nextState;
  end

  // Enable is gated by rst combinationally so a store caught mid-access never lands.
  always_comb begin
    // NOTE: defaults first on every path, otherwise the combinational block infers latches.
    nextState = state;
    mem_en    = 1'b0;
    mem_wren  = 1'b0;
    case (state)
      IDLE:    if (anyReq) nextState = ACCESS;
      ACCESS: begin
        mem_en    = legal & ~rst;
        mem_wren  = legal & curWe & ~rst;
        nextState = RESP;
      end
      RESP:    nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      gntQ     <= '0;
      rvalidQ  <= '0;
      errQ     <= '0;
      rdataQ   <= '0;
      curPort  <= 1'b0;
      curWe    <= 1'b0;
      curOp    <= '0;
      curAddr  <= '0;
      curWdata <= '0;
    end else begin
      gntQ    <= '0;
      rvalidQ <= '0;
      if (accept) begin
        gntQ[winner] <= 1'b1;
        curPort      <= winner;
        if (winner) begin
          curWe    <= r1.we;
          curOp    <= r1.op;
          curAddr  <= r1.addr;
          curWdata <= r1.wdata;
        end else begin
          curWe    <= r0.we;
          curOp    <= r0.op;
          curAddr  <= r0.addr;
          curWdata <= r0.wdata;
        end
      end
      if (state == ACCESS) begin
        rvalidQ[curPort] <= 1'b1;
        rdataQ[curPort]  <= accessData;
        errQ[curPort]    <= ~legal;
      end
    end
  end

  assign mem_op    = curOp;
  assign mem_addr  = curAddr;
  assign mem_wdata = curWdata;

  assign r0.gnt    = gntQ[0];
  assign r0.rvalid = rvalidQ[0];
  assign r0.rdata  = rdataQ[0];
  assign r0.err    = errQ[0];
  assign r1.gnt    = gntQ[1];
  assign r1.rvalid = rvalidQ[1];
  assign r1.rdata  = rdataQ[1];
  assign r1.err    = errQ[1];

endmodule
